// File: rtl/dmem_pkg.sv
// Shared definitions for the wait-state data memory: access size codes,
// controller state type and the request legality check.
package dmem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        ACCESS,
        RESP
    } state_t;

    // Misaligned halves/words and the reserved size code are rejected.
    function automatic logic req_err(
        input logic [1:0] size,
        input logic [1:0] lo
    );
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lo[0];
            SZ_WORD: return lo != 2'b00;
            default: return 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: store byte enables / replicated store data
// and load byte/half extraction with sign or zero extension.
// Ports: size_i, unsigned_i, addr_lo_i, wdata_i, rword_i -> be_o, wdata_o, rdata_o
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [31:0] wdata_i,
    input  logic [31:0] rword_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] rdata_o
);

    logic [7:0]  rbyte;
    logic [15:0] rhalf;

    assign rbyte = rword_i[{addr_lo_i, 3'b000} +: 8];
    assign rhalf = addr_lo_i[1] ? rword_i[31:16] : rword_i[15:0];

    // Store data is replicated across lanes; the byte enables pick the lane.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = wdata_i;
        rdata_o = '0;
        case (size_i)
            SZ_BYTE: begin
                be_o    = 4'b0001 << addr_lo_i;
                wdata_o = {4{wdata_i[7:0]}};
                rdata_o = {{24{rbyte[7] & ~unsigned_i}}, rbyte};
            end
            SZ_HALF: begin
                be_o    = addr_lo_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                rdata_o = {{16{rhalf[15] & ~unsigned_i}}, rhalf};
            end
            SZ_WORD: begin
                be_o    = 4'b1111;
                rdata_o = rword_i;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/data_memory_ws.sv
// Single-port data memory with WAIT_CYCLES programmable wait states.
// Ports: clk, rst_n, req_* request (valid/ready), address, write_data,
// resp_valid/resp_err/read_data one-cycle response.
module data_memory_ws
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 14,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        resp_valid,
    output logic        resp_err,
    output logic [31:0] read_data
);

    localparam int         DEPTH     = 2 ** (ADDR_W - 2);
    localparam logic [2:0] WAIT_INIT = 3'(WAIT_CYCLES);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                write_q;
    logic                uns_q;
    logic [1:0]          size_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                err_q;

    logic                accept;
    logic                req_bad;
    logic                cur_bad;
    logic [3:0]          be;
    logic [31:0]         wdata_al;
    logic [31:0]         rdata_ext;
    logic [31:0]         rword;
    logic [ADDR_W-3:0]   widx;

    // Zero at power-up only; reset deliberately leaves contents alone.
    logic [31:0] mem [DEPTH] = '{default: '0};

    // High address bits alias onto the decoded range.
    logic unused_addr;
    assign unused_addr = ^address[31:ADDR_W];

    assign accept     = (state_q == IDLE) && req_valid;
    assign req_bad    = req_err(req_size, address[1:0]);
    assign cur_bad    = req_err(size_q, addr_q[1:0]);
    assign widx       = addr_q[ADDR_W-1:2];
    assign rword      = mem[widx];
    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign resp_err   = err_q;
    assign read_data  = rdata_q;

    dmem_lane_align u_align (
        .size_i     (size_q),
        .unsigned_i (uns_q),
        .addr_lo_i  (addr_q[1:0]),
        .wdata_i    (wdata_q),
        .rword_i    (rword),
        .be_o       (be),
        .wdata_o    (wdata_al),
        .rdata_o    (rdata_ext)
    );

    // Erroneous requests skip the wait states: there is nothing to access.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    cnt_d   = WAIT_INIT;
                    state_d = (WAIT_CYCLES == 0 || req_bad) ? ACCESS : WAIT;
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 3'd1;
                if (cnt_q == 3'd1) state_d = ACCESS;
            end
            ACCESS:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            uns_q   <= 1'b0;
            size_q  <= SZ_BYTE;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                write_q <= req_write;
                uns_q   <= req_unsigned;
                size_q  <= req_size;
                addr_q  <= address[ADDR_W-1:0];
                wdata_q <= write_data;
            end
            if (state_q == ACCESS) begin
                err_q   <= cur_bad;
                rdata_q <= (cur_bad || write_q) ? '0 : rdata_ext;
            end
        end
    end

    // Reset forces IDLE asynchronously, so a pending store never lands.
    always_ff @(posedge clk) begin
        if (state_q == ACCESS && write_q && !cur_bad) begin
            for (int i = 0; i < 4; i++) begin
                if (be[i]) mem[widx][8*i +: 8] <= wdata_al[8*i +: 8];
            end
        end
    end

endmodule

// File: tb/tb_data_memory_ws.sv
// Scoreboard bench for data_memory_ws: two instances (1 and 3 wait states)
// checked against a byte-array reference model.
module tb_data_memory_ws;

    localparam int MEMB = 16384;

    typedef struct {
        logic [31:0] data;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n        [2];
    logic        req_valid    [2];
    logic        req_ready    [2];
    logic        req_write    [2];
    logic [1:0]  req_size     [2];
    logic        req_unsigned [2];
    logic [31:0] address      [2];
    logic [31:0] write_data   [2];
    logic        resp_valid   [2];
    logic        resp_err     [2];
    logic [31:0] read_data    [2];

    logic [7:0]  mb [2][MEMB];
    exp_t        q0 [$];
    exp_t        q1 [$];
    int          cyc = 0;
    int          checks = 0;
    int          errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    data_memory_ws #(.ADDR_W(14), .WAIT_CYCLES(1)) dut0 (
        .clk(clk), .rst_n(rst_n[0]),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]),
        .req_write(req_write[0]), .req_size(req_size[0]),
        .req_unsigned(req_unsigned[0]), .address(address[0]),
        .write_data(write_data[0]), .resp_valid(resp_valid[0]),
        .resp_err(resp_err[0]), .read_data(read_data[0])
    );

    data_memory_ws #(.ADDR_W(14), .WAIT_CYCLES(3)) dut1 (
        .clk(clk), .rst_n(rst_n[1]),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]),
        .req_write(req_write[1]), .req_size(req_size[1]),
        .req_unsigned(req_unsigned[1]), .address(address[1]),
        .write_data(write_data[1]), .resp_valid(resp_valid[1]),
        .resp_err(resp_err[1]), .read_data(read_data[1])
    );

    function automatic int wc(int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int nbytes(logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_err(logic [1:0] sz, logic [31:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
               (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic void model_store(int d, logic [1:0] sz,
                                        logic [31:0] a, logic [31:0] wd);
        int b;
        b = int'(a & 32'h3FFF);
        for (int i = 0; i < nbytes(sz); i++) mb[d][b + i] = wd[8*i +: 8];
    endfunction

    function automatic logic [31:0] model_load(int d, logic [1:0] sz,
                                               bit u, logic [31:0] a);
        int b;
        int n;
        logic [31:0] v;
        b = int'(a & 32'h3FFF);
        n = nbytes(sz);
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mb[d][b + i];
        if (!u && n < 4 && v[8*n - 1]) v = v | (32'hFFFF_FFFF << (8*n));
        return v;
    endfunction

    task automatic chk(string nm, int d, logic [31:0] got, logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s dut%0d got %h exp %h", nm, d, got, want);
        end
    endtask

    task automatic issue(int d, bit w, logic [1:0] sz, bit u,
                         logic [31:0] a, logic [31:0] wd, bit abort = 1'b0);
        int   t;
        int   nlow;
        bit   bad;
        exp_t e;
        t = 0;
        @(negedge clk);
        while (!req_ready[d] && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            chk("ready_timeout", d, 32'd0, 32'd1);
            return;
        end
        req_valid[d]    = 1'b1;
        req_write[d]    = w;
        req_size[d]     = sz;
        req_unsigned[d] = u;
        address[d]      = a;
        write_data[d]   = wd;
        @(posedge clk);
        #1;
        req_valid[d]  = 1'b0;
        address[d]    = $urandom;
        write_data[d] = $urandom;
        bad = model_err(sz, a);
        if (abort) begin
            @(negedge clk);
            rst_n[d] = 1'b0;
            #1;
            chk("abort_resp_valid", d, 32'(resp_valid[d]), 32'd0);
            chk("abort_req_ready", d, 32'(req_ready[d]), 32'd1);
            @(negedge clk);
            rst_n[d] = 1'b1;
            return;
        end
        e.err  = bad;
        e.data = (bad || w) ? 32'd0 : model_load(d, sz, u, a);
        e.cyc  = cyc + (bad ? 1 : wc(d) + 1);
        if (!bad && w) model_store(d, sz, a, wd);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
        nlow = 0;
        @(negedge clk);
        while (!req_ready[d] && nlow < 50) begin
            nlow++;
            @(negedge clk);
        end
        chk("ready_low_cycles", d, 32'(nlow), 32'(bad ? 2 : wc(d) + 2));
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (rst_n[d] === 1'b1 && resp_valid[d] === 1'b1) begin
                if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                    chk("unexpected_resp", d, 32'd1, 32'd0);
                end else begin
                    e = (d == 0) ? q0.pop_front() : q1.pop_front();
                    chk("resp_data", d, read_data[d], e.data);
                    chk("resp_err", d, 32'(resp_err[d]), 32'(e.err));
                    chk("resp_cycle", d, 32'(cyc), 32'(e.cyc));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < MEMB; i++) mb[d][i] = 8'h00;
            rst_n[d]        = 1'b0;
            req_valid[d]    = 1'b0;
            req_write[d]    = 1'b0;
            req_size[d]     = 2'b00;
            req_unsigned[d] = 1'b0;
            address[d]      = '0;
            write_data[d]   = '0;
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_req_ready", d, 32'(req_ready[d]), 32'd1);
            chk("rst_resp_valid", d, 32'(resp_valid[d]), 32'd0);
            chk("rst_resp_err", d, 32'(resp_err[d]), 32'd0);
            chk("rst_read_data", d, read_data[d], 32'd0);
        end
        repeat (3) @(negedge clk);
        rst_n[0] = 1'b1;
        rst_n[1] = 1'b1;

        // word store/load
        issue(0, 1, 2'b10, 0, 32'h10, 32'hDEAD_BEEF);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0);
        // byte store with signed/unsigned loads
        issue(0, 1, 2'b10, 0, 32'h20, 32'h0);
        issue(0, 1, 2'b00, 0, 32'h21, 32'h0000_0080);
        issue(0, 0, 2'b00, 0, 32'h21, 32'h0);
        issue(0, 0, 2'b00, 1, 32'h21, 32'h0);
        issue(0, 0, 2'b10, 0, 32'h20, 32'h0);
        // half store over a zero word
        issue(0, 1, 2'b10, 0, 32'h30, 32'h0);
        issue(0, 1, 2'b01, 0, 32'h32, 32'h0000_1234);
        issue(0, 0, 2'b10, 0, 32'h30, 32'h0);
        issue(0, 0, 2'b01, 0, 32'h32, 32'h0);
        // erroneous requests leave the array untouched
        issue(0, 1, 2'b10, 0, 32'h40, 32'h1122_3344);
        issue(0, 1, 2'b10, 0, 32'h42, 32'hFFFF_FFFF);
        issue(0, 0, 2'b01, 0, 32'h43, 32'h0);
        issue(0, 1, 2'b11, 0, 32'h40, 32'hFFFF_FFFF);
        issue(0, 1, 2'b01, 0, 32'h41, 32'hFFFF_FFFF);
        issue(0, 0, 2'b10, 0, 32'h40, 32'h0);
        // aliasing above ADDR_W
        issue(0, 1, 2'b10, 0, 32'h0000_4010, 32'hCAFE_F00D);
        issue(0, 0, 2'b10, 0, 32'h10, 32'h0);
        issue(0, 1, 2'b01, 0, 32'h12, 32'h0000_5A5A);
        issue(0, 0, 2'b10, 0, 32'h8000_4010, 32'h0);

        // reset aborts a pending store on the 3-wait-state instance
        issue(1, 1, 2'b10, 0, 32'h50, 32'h0);
        issue(1, 1, 2'b00, 0, 32'h50, 32'h0000_0055, 1'b1);
        issue(1, 0, 2'b10, 0, 32'h50, 32'h0);
        issue(1, 0, 2'b00, 1, 32'h50, 32'h0);

        for (int d = 0; d < 2; d++) begin
            for (int k = 0; k < 40; k++) begin
                logic [31:0] a;
                a = 32'h100 + 32'($urandom_range(0, 127));
                if ($urandom_range(0, 3) == 0) a = a | ($urandom & 32'hFFFF_C000);
                issue(d, 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                      1'($urandom_range(0, 1)), a, $urandom);
            end
        end

        repeat (8) @(negedge clk);
        chk("q0_drained", 0, 32'(q0.size()), 32'd0);
        chk("q1_drained", 1, 32'(q1.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_memory_ws.md
DATA_MEMORY_WS -- requirements
Module: data_memory_ws

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 14, meaning byte-address bits decoded; the array holds 2**(ADDR_W-2) 32-bit words.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1, range 0..7, meaning extra wait states inserted before the array access.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port req_valid, input, 1 bit: request present.
REQ-006 The block SHALL have port req_ready, output, 1 bit: block can accept a request.
REQ-007 The block SHALL have port req_write, input, 1 bit: 1 = store, 0 = load.
REQ-008 The block SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-009 The block SHALL have port req_unsigned, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-010 The block SHALL have port address, input, 32 bits: byte address; bits above ADDR_W-1 are ignored (aliasing).
REQ-011 The block SHALL have port write_data, input, 32 bits: store data, LSB-aligned.
REQ-012 The block SHALL have port resp_valid, output, 1 bit: one-cycle response pulse.
REQ-013 The block SHALL have port resp_err, output, 1 bit: misaligned or illegal-size request, qualified by resp_valid.
REQ-014 The block SHALL have port read_data, output, 32 bits: extended load result.

Function
REQ-015 The FSM SHALL have states IDLE, WAIT, ACCESS and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 In IDLE, req_valid=1 SHALL capture write, size, unsigned, address and write_data, load the wait counter with WAIT_CYCLES, and go to WAIT, or to ACCESS when WAIT_CYCLES=0 or the request is erroneous.
REQ-017 WAIT SHALL decrement the counter each cycle and go to ACCESS on the edge where the counter reaches 0.
REQ-018 ACCESS SHALL perform the array write or read on its exiting edge, register read_data and resp_err, then go to RESP.
REQ-019 RESP SHALL assert resp_valid for exactly one cycle, then return to IDLE; there is no response backpressure.
REQ-020 Latency SHALL be: with the accept edge counted as edge 1, the access occurs on edge WAIT_CYCLES+2 and resp_valid is high during the following cycle.
REQ-021 Throughput SHALL be one request per WAIT_CYCLES+3 cycles.
REQ-022 Byte lanes SHALL be little-endian, selected by address[1:0].
REQ-023 A byte store SHALL write only lane address[1:0] with write_data[7:0].
REQ-024 A half store SHALL write only lanes {address[1],0} and {address[1],1} with write_data[15:0].
REQ-025 A word store SHALL write all 4 lanes.
REQ-026 Loads SHALL extract the addressed byte or half, then sign- or zero-extend it to 32 bits per req_unsigned.
REQ-027 resp_err SHALL be 1 for: half with address[0]=1; word with address[1:0]!=00; size 11.
REQ-028 An erroneous request SHALL not modify the array and SHALL return read_data=0.
REQ-029 A store response SHALL return read_data=0 and resp_err=0.
REQ-030 read_data and resp_err SHALL hold their value until the next ACCESS edge.
REQ-031 Inputs SHALL be ignored outside IDLE.

Reset
REQ-032 rst_n=0 SHALL immediately force state IDLE, wait counter 0, resp_valid 0, resp_err 0 and read_data 0; req_ready SHALL be 1 while rst_n=0.
REQ-033 Reset SHALL not clear the array; the array SHALL be zero-initialised at simulation start only.
REQ-034 Reset asserted before the ACCESS edge SHALL abort the pending store with no array change.

Structure
REQ-035 A shared package dmem_pkg SHALL hold the size encodings (SZ_BYTE, SZ_HALF, SZ_WORD) and the FSM state type.
REQ-036 A combinational sub-module dmem_lane_align SHALL perform the store byte-enable/data alignment and the load extract/extend.

Verification
REQ-037 The bench SHALL cover: WAIT_CYCLES=1; word store 0xDEADBEEF @0x10, then word load @0x10 -> read_data=0xDEADBEEF, resp_valid on the cycle after edge 3, req_ready low 3 cycles.
REQ-038 The bench SHALL cover: byte store 0x80 @0x21, then lb @0x21 -> 0xFFFFFF80; lbu -> 0x00000080; word load @0x20 -> 0x00008000.
REQ-039 The bench SHALL cover: half store 0x1234 @0x32 over word 0 -> word @0x30 = 0x12340000; lh @0x32 -> 0x00001234.
REQ-040 The bench SHALL cover: word store @0x42 or half load @0x43 or size=11 -> resp_err=1, read_data=0, array unchanged.
REQ-041 The bench SHALL cover: WAIT_CYCLES=3; rst_n pulsed low during WAIT of a store 0x55 @0x50 -> resp_valid 0, req_ready 1 immediately, later load @0x50 -> 0.
REQ-042 The bench SHALL cover: address 0x00004010 with ADDR_W=14 aliases 0x10 -> store/load sees the same word.
